node_mac_seq: RTL
=================

# node_mac_seq

Parametrised, time-multiplexed neuron node for the ECG inference layers. It computes one weighted sum of N_IN IEEE-754 single-precision activations against a locally stored weight vector, then applies an activation, and presents the result on a valid/ready output. A single `float_mult` and a single `float_adder` are reused across one accepted input per cycle, replacing per-input multiplier/adder chains.

## Interface
- N_IN, 30, number of inputs summed per result (≥2)
- ACT_MODE, 0, 0 = ReLU (sign bit set → +0.0), 1 = identity
- AW, $clog2(N_IN+1), weight address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a new sum; sampled only in IDLE
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  32  activation, float32
- w_we  in  1  weight write strobe
- w_addr  in  AW  weight index 0..N_IN-1 (N_IN = bias slot, see Configuration)
- w_data  in  32  weight value, float32
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  32  activated sum, float32
- busy  out  1  state ≠ IDLE

## Operation
- Weight store: N_IN × 32-bit registers, reset to 0x00000000. A write takes effect only when w_we=1, state=IDLE, and w_addr<N_IN. Otherwise the write is dropped.
- FSM states: IDLE, ACC, OUT.
- IDLE → ACC on start=1. Clears acc to 0x00000000 and idx to 0.
- ACC: in_ready=1. A beat is accepted when in_valid && in_ready. On acceptance: acc ← float_adder(acc, float_mult(in_data, W[idx])) and idx ← idx+1.
- Summation order is strictly index 0..N_IN-1. Each input contributes exactly once.
- ACC → OUT on acceptance with idx==N_IN-1. out_data ← act(final sum), registered.
- OUT: out_valid=1 and out_data held stable until out_ready=1. Then go to IDLE.
- out_valid && out_ready with start=1 in the same cycle: go to IDLE only. A start is never taken from OUT.
- start while busy: ignored.
- in_valid outside ACC: ignored, because in_ready=0.
- ReLU: any result with bit31=1, including −0.0 and negative NaN, outputs 0x00000000. Otherwise the value passes through unchanged.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0x00000000, busy=0, acc=0, idx=0, state=IDLE, all weights 0.
- Reset assertion mid-operation aborts immediately. The partial sum is discarded and the weights are cleared.
- start at cycle t gives in_ready=1 from t+1.
- The last beat accepted at cycle k gives out_valid=1 at k+1.
- Minimum latency from start to out_valid is N_IN+1 cycles.
- Throughput is one result per N_IN+2 cycles with back-to-back start.
- Input bubbles (in_valid=0) stall idx and acc with no side effects.
- Multiply-add is combinational within one cycle; no internal pipeline.

## Configuration
- NODE_BIAS_EN defined:
  - Adds a 32-bit bias register, reset 0, written via w_addr==N_IN under the same IDLE rule.
  - On start, acc is initialised to the bias instead of 0.
- NODE_BIAS_EN undefined:
  - No bias register.
  - Writes to w_addr==N_IN are dropped.
  - acc is initialised to 0.

## Test plan
- N_IN=4, ACT_MODE=0, all weights 0x3F800000 (1.0), inputs 1.0,1.0,1.0,1.0 back-to-back → out_valid 5 cycles after start, out_data=0x40800000 (4.0).
- Same setup with weights 0xBF800000 (−1.0):
  - ACT_MODE=0 → out_data=0x00000000.
  - ACT_MODE=1 → out_data=0xC0800000 (−4.0).
- Weights {1.0,2.0,3.0,4.0}, inputs 1.0 with in_valid toggled every other cycle, out_ready held low 3 cycles:
  - out_data=0x41200000 (10.0).
  - out_data stays stable while stalled.
  - Only 4 beats are consumed.
- During ACC, w_we=1 writing w_addr=0 with 0x40000000 and pulsing start → the write and the start have no effect. The result matches the pre-write weights and the FSM sequence is unchanged.
- rst_n low after 2 of 4 beats → all outputs return to their reset values. A following full run with fresh weights gives the correct sum, with no residue from the aborted run.
- NODE_BIAS_EN, bias 0x3F000000 (0.5), first scenario → out_data=0x40900000 (4.5). Without the macro, the same write is dropped and the result is 0x40800000.

Source files
------------

// File: rtl/node_mac_seq_if.sv
// Handshake, weight-load and result bus of node_mac_seq.
interface node_mac_seq_if #(
  parameter int AW = 5
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;

  modport master (
    output start, in_valid, in_data, w_we, w_addr, w_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, in_valid, in_data, w_we, w_addr, w_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/node_mac_seq.sv
// Time-multiplexed float32 neuron: one multiply-add per accepted beat, then activation.
// Optional NODE_BIAS_EN adds a bias register at w_addr == N_IN that seeds the sum.
module node_mac_seq #(
  parameter int N_IN     = 30,
  parameter int ACT_MODE = 0,
  parameter int AW       = $clog2(N_IN + 1)
) (
  input logic           clk,
  input logic           rst_n,
  node_mac_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Subnormals are flushed to zero; rounding is round-to-nearest-even.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic              sign;
    logic [47:0]       p;
    logic [22:0]       frac;
    logic              g, st;
    logic signed [9:0] e;
    logic [23:0]       r;
    sign = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) return QNAN;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return QNAN;
      return {sign, 8'hFF, 23'd0};
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sign, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      frac = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
    end else begin
      frac = p[45:23]; g = p[22]; st = |p[21:0];
    end
    r = {1'b0, frac} + {23'd0, g & (st | frac[0])};
    if (r[23]) e = e + 10'sd1;
    if (e >= 10'sd255) return {sign, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {sign, 31'd0};
    return {sign, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic [27:0]       s;
    logic signed [9:0] e;
    logic [4:0]        lz;
    logic              found;
    logic [23:0]       r;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) return QNAN;
    if (a[30:23] == 8'hFF) return (b[30:23] == 8'hFF && a[31] != b[31]) ? QNAN : a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Three extra LSBs: guard, round and a sticky bit collecting everything shifted out.
    if (d > 8'd26) my = 27'd1;
    else my = (my >> d) | {26'd0, |(my & ~(27'h7FF_FFFF << d))};
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      if (s == 28'd0) return '0;
    end
    lz = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!found && s[26 - i]) begin
        found = 1'b1;
        lz = 5'(i);
      end
    end
    s = s << lz;
    e = e - $signed({5'd0, lz});
    r = {1'b0, s[25:3]} + {23'd0, s[2] & (s[1] | s[0] | s[3])};
    if (r[23]) e = e + 10'sd1;
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return {x[31], 31'd0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] act(input logic [31:0] v);
    if (ACT_MODE == 0 && v[31]) return '0;
    return v;
  endfunction

  state_t        state;
  logic [31:0]   acc;
  logic [AW-1:0] idx;
  logic          accepting;
  logic          result_valid;
  logic [31:0]   result;
  logic          active;
  logic [31:0]   weight [N_IN];
  logic [31:0]   acc_init;
  logic [31:0]   sum_next;

`ifdef NODE_BIAS_EN
  logic [31:0] bias;
  assign acc_init = bias;
`else
  assign acc_init = '0;
`endif

  assign sum_next = fadd(acc, fmul(bus.in_data, weight[idx]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_IN; i++) weight[i] <= '0;
`ifdef NODE_BIAS_EN
      bias <= '0;
`endif
    end else if (bus.w_we && state == IDLE) begin
      if (bus.w_addr < AW'(N_IN)) weight[bus.w_addr] <= bus.w_data;
`ifdef NODE_BIAS_EN
      else if (bus.w_addr == AW'(N_IN)) bias <= bus.w_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      accepting    <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      active       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state     <= ACC;
          acc       <= acc_init;
          idx       <= '0;
          accepting <= 1'b1;
          active    <= 1'b1;
        end
        ACC: if (bus.in_valid && accepting) begin
          acc <= sum_next;
          idx <= idx + AW'(1);
          if (idx == AW'(N_IN - 1)) begin
            state        <= OUT;
            accepting    <= 1'b0;
            result_valid <= 1'b1;
            result       <= act(sum_next);
          end
        end
        OUT: if (bus.out_ready) begin
          state        <= IDLE;
          result_valid <= 1'b0;
          active       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = accepting;
  assign bus.out_valid = result_valid;
  assign bus.out_data  = result;
  assign bus.busy      = active;

endmodule
